uart_baud_gen: RTL and testbench

- Parametrised successor to the UART RX divided-clock generator.
- Replaces the fixed integer toggle divider with a fractional phase accumulator. Produces single-cycle clock-enable strobes instead of a derived clock.
- Outputs: oversample strobe, bit strobe and mid-bit sample strobe, for both the UART RX and TX paths.
- Baud increment is reprogrammable at runtime. The RX path can realign the bit phase on start-bit detection.

---
 rtl/uart_baud_gen.sv | 118 +++++++++++
 tb/tb_uart_baud_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// Fractional-N UART baud strobe generator: oversample, bit and mid-bit enables.
// Define UART_BAUD_CLK_OUT_EN to add the legacy square-wave output clk_rx.
module uart_baud_gen #(
    parameter int unsigned       FSYS_CLK     = 50_000_000,
    parameter int unsigned       BAUD_DEFAULT = 115200,
    parameter int unsigned       OVERSAMPLE   = 16,
    parameter int unsigned       ACC_W        = 24,
    parameter logic [ACC_W-1:0]  INC_DEFAULT  = ACC_W'(
        (64'(BAUD_DEFAULT) * 64'(OVERSAMPLE) * (64'd1 << ACC_W) + 64'(FSYS_CLK / 2))
        / 64'(FSYS_CLK)),
    localparam int unsigned      PHASE_W      = $clog2(OVERSAMPLE)
) (
    input  logic               clk_50mhz,
    input  logic               rst,
    input  logic               en,
    input  logic               realign,
    input  logic               cfg_wr,
    input  logic [ACC_W-1:0]   cfg_inc,
    output logic [ACC_W-1:0]   inc_q,
    output logic               os_tick,
    output logic               bit_tick,
    output logic               mid_tick,
    output logic [PHASE_W-1:0] os_phase
`ifdef UART_BAUD_CLK_OUT_EN
    ,
    output logic               clk_rx
`endif
);

    localparam logic [PHASE_W-1:0] PhaseLast = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PhaseMid  = PHASE_W'(OVERSAMPLE / 2 - 1);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   inc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               os_q, os_d;
    logic               bit_q, bit_d;
    logic               mid_q, mid_d;
    logic [ACC_W:0]     sum;
    logic               carry;

    // Extra bit catches the overflow that marks one oversample period.
    assign sum   = {1'b0, acc_q} + {1'b0, inc_q};
    assign carry = sum[ACC_W];

    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        inc_d   = cfg_wr ? cfg_inc : inc_q;
        os_d    = 1'b0;
        bit_d   = 1'b0;
        mid_d   = 1'b0;
        if (realign) begin
            acc_d   = '0;
            phase_d = '0;
        end else if (en) begin
            acc_d = sum[ACC_W-1:0];
            os_d  = carry;
            if (carry) begin
                if (phase_q == PhaseLast) begin
                    phase_d = '0;
                    bit_d   = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
                mid_d = (phase_q == PhaseMid);
            end
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            acc_q   <= '0;
            inc_q   <= INC_DEFAULT;
            phase_q <= '0;
            os_q    <= 1'b0;
            bit_q   <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            inc_q   <= inc_d;
            phase_q <= phase_d;
            os_q    <= os_d;
            bit_q   <= bit_d;
            mid_q   <= mid_d;
        end
    end

    assign os_tick  = os_q;
    assign bit_tick = bit_q;
    assign mid_tick = mid_q;
    assign os_phase = phase_q;

`ifdef UART_BAUD_CLK_OUT_EN
    logic clk_rx_q, clk_rx_d;

    // Toggles alongside each os_tick rise, so it runs at half the oversample rate.
    always_comb begin
        clk_rx_d = clk_rx_q;
        if (realign) begin
            clk_rx_d = 1'b0;
        end else if (en && carry) begin
            clk_rx_d = ~clk_rx_q;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            clk_rx_q <= 1'b0;
        end else begin
            clk_rx_q <= clk_rx_d;
        end
    end

    assign clk_rx = clk_rx_q;
`endif

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: directed scenarios plus randomized traffic
// checked against an arithmetic phase model.
module tb_uart_baud_gen;

    localparam int    ACC_W   = 24;
    localparam int    OS      = 16;
    localparam int    PW      = 4;
    localparam longint INC_DEF = 618475;
    localparam longint MODV    = 64'd1 << ACC_W;

    logic             clk_50mhz = 1'b0;
    logic             rst       = 1'b1;
    logic             en        = 1'b0;
    logic             realign   = 1'b0;
    logic             cfg_wr    = 1'b0;
    logic [ACC_W-1:0] cfg_inc   = '0;
    logic [ACC_W-1:0] inc_q;
    logic             os_tick, bit_tick, mid_tick;
    logic [PW-1:0]    os_phase;
`ifdef UART_BAUD_CLK_OUT_EN
    logic             clk_rx;
`endif

    uart_baud_gen dut (
        .clk_50mhz (clk_50mhz),
        .rst       (rst),
        .en        (en),
        .realign   (realign),
        .cfg_wr    (cfg_wr),
        .cfg_inc   (cfg_inc),
        .inc_q     (inc_q),
        .os_tick   (os_tick),
        .bit_tick  (bit_tick),
        .mid_tick  (mid_tick),
        .os_phase  (os_phase)
`ifdef UART_BAUD_CLK_OUT_EN
        ,
        .clk_rx    (clk_rx)
`endif
    );

    always #5 clk_50mhz = ~clk_50mhz;

    int checks = 0;
    int errors = 0;

    // Model: phase as an integer fraction of MODV, ticks counted since last realign.
    longint m_acc = 0;
    longint m_inc = INC_DEF;
    longint m_n   = 0;
    logic   m_os = 0, m_bit = 0, m_mid = 0, m_clk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic e, input logic ra, input logic cw, input longint ci);
        longint s;
        longint nxt_inc;
        if (rst) begin
            m_acc = 0; m_inc = INC_DEF; m_n = 0;
            m_os = 0; m_bit = 0; m_mid = 0; m_clk = 0;
        end else begin
            nxt_inc = cw ? ci : m_inc;
            m_os = 0; m_bit = 0; m_mid = 0;
            if (ra) begin
                m_acc = 0; m_n = 0; m_clk = 0;
            end else if (e) begin
                s = m_acc + m_inc;
                if (s >= MODV) begin
                    s     = s - MODV;
                    m_n   = m_n + 1;
                    m_os  = 1;
                    m_bit = (m_n % OS == 0);
                    m_mid = (m_n % OS == OS / 2);
                    m_clk = ~m_clk;
                end
                m_acc = s;
            end
            m_inc = nxt_inc;
        end
    endtask

    task automatic step(input logic e, input logic ra, input logic cw, input longint ci);
        en = e; realign = ra; cfg_wr = cw; cfg_inc = ACC_W'(ci);
        @(posedge clk_50mhz);
        model_edge(e, ra, cw, ci);
        #1;
        chk("inc_q", 64'(inc_q), 64'(m_inc));
        chk("os_phase", 64'(os_phase), 64'(m_n % OS));
        chk("os_tick", 64'(os_tick), 64'(m_os));
        chk("bit_tick", 64'(bit_tick), 64'(m_bit));
        chk("mid_tick", 64'(mid_tick), 64'(m_mid));
`ifdef UART_BAUD_CLK_OUT_EN
        chk("clk_rx", 64'(clk_rx), 64'(m_clk));
`endif
    endtask

    initial begin
        int n, n_os, n_bit, n_mid, last_os, last_bit, hold_ph, gaps;
        logic found;

        // Reset held 3 cycles
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("reset_inc", 64'(inc_q), 64'(INC_DEF));
        chk("reset_phase", 64'(os_phase), 64'd0);
        rst = 1'b0;

        // First os_tick after release
        n = 0; found = 0;
        while (!found && n < 100) begin
            step(1, 0, 0, 0);
            n++;
            if (os_tick) found = 1;
        end
        chk("first_os_cycle", 64'(n), 64'd28);

        // Fractional accuracy with default increment
        step(1, 1, 0, 0);
        n_os = 0; n_bit = 0;
        for (int i = 0; i < 30000; i++) begin
            step(1, 0, 0, 0);
            if (os_tick) n_os++;
            if (bit_tick) n_bit++;
        end
        chk("frac_os_count", 64'(n_os), 64'((30000 * INC_DEF) / MODV));
        chk("frac_bit_count", 64'(n_bit), 64'(((30000 * INC_DEF) / MODV) / OS));

        // Exact divider: cfg_wr and realign on the same edge
        step(1, 1, 1, 64'd1 << 20);
        n_os = 0; n_bit = 0; n_mid = 0; last_os = -1; last_bit = -1;
        for (int i = 1; i <= 4096; i++) begin
            step(1, 0, 0, 0);
            if (os_tick) begin
                n_os++;
                if (last_os >= 0) chk("os_gap16", 64'(i - last_os), 64'd16);
                last_os = i;
            end
            if (bit_tick) begin
                n_bit++;
                if (last_bit >= 0) chk("bit_gap256", 64'(i - last_bit), 64'd256);
                last_bit = i;
            end
            if (mid_tick) begin
                n_mid++;
                if (last_bit >= 0) chk("mid_after_bit", 64'(i - last_bit), 64'd128);
            end
        end
        chk("exact_os_count", 64'(n_os), 64'd256);
        chk("exact_bit_count", 64'(n_bit), 64'd16);
        chk("exact_mid_count", 64'(n_mid), 64'd16);

        // Realign at os_phase 5
        n = 0;
        while (os_phase != 5 && n < 200) begin
            step(1, 0, 0, 0);
            n++;
        end
        chk("reach_phase5", 64'(os_phase), 64'd5);
        step(1, 1, 0, 0);
        chk("realign_phase", 64'(os_phase), 64'd0);
        chk("realign_os", 64'(os_tick), 64'd0);
        n = 0; found = 0;
        while (!found && n < 300) begin
            step(1, 0, 0, 0);
            n++;
            if (mid_tick) found = 1;
        end
        chk("realign_to_mid", 64'(n), 64'd128);

        // Drop en for 50 cycles
        for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
        hold_ph = int'(os_phase);
        n_os = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 0);
            if (os_tick || bit_tick || mid_tick) n_os++;
        end
        chk("en_off_strobes", 64'(n_os), 64'd0);
        chk("en_off_phase", 64'(os_phase), 64'(hold_ph));
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0);

        // Reprogram to 2^21 while running
        step(1, 0, 1, 64'd1 << 21);
        last_os = -1; gaps = 0; n = 0;
        while (gaps < 5 && n < 200) begin
            step(1, 0, 0, 0);
            n++;
            if (os_tick) begin
                if (last_os >= 0) begin
                    chk("os_gap8", 64'(n - last_os), 64'd8);
                    gaps++;
                end
                last_os = n;
            end
        end
        chk("gap8_seen", 64'(gaps), 64'd5);

`ifdef UART_BAUD_CLK_OUT_EN
        step(1, 1, 1, 64'd1 << 20);
        chk("clk_rx_realign", 64'(clk_rx), 64'd0);
        last_os = -1; gaps = 0; n = 0; found = 0;
        while (gaps < 2 && n < 300) begin
            step(1, 0, 0, 0);
            n++;
            if (clk_rx && !found) begin
                if (last_os >= 0) begin
                    chk("clk_rx_period", 64'(n - last_os), 64'd32);
                    gaps++;
                end
                last_os = n;
            end
            found = clk_rx;
        end
        chk("clk_rx_periods", 64'(gaps), 64'd2);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 20000; i++) begin
            logic e, ra, cw;
            longint ci;
            rst = ($urandom_range(0, 4999) == 0);
            e   = ($urandom_range(0, 9) != 0);
            ra  = ($urandom_range(0, 499) == 0);
            cw  = ($urandom_range(0, 999) == 0);
            ci  = ($urandom_range(0, 7) == 0) ? 0 : longint'($urandom_range(1 << 14, 1 << 21));
            step(e, ra, cw, ci);
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
